// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types.
// Used by the fetch stage, its skid buffer and the IF/ID interface.
package mips_pkg;

    localparam int          INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side bus of the IF/ID stage: imem port, hazard
// controls and the registered decode-facing outputs.
interface if_id_stage_if #(
    parameter int W = mips_pkg::INSTR_W
);
    logic [W-1:0] imem_addr_o;
    logic [W-1:0] imem_data_i;
    logic         stall_i;
    logic         redirect_i;
    logic [W-1:0] redirect_pc_i;
    logic [W-1:0] instr_o;
    logic [15:0]  imm_o;
    logic [W-1:0] pc_plus4_o;
    logic         valid_o;

    modport master (
        output imem_addr_o,
        output instr_o,
        output imm_o,
        output pc_plus4_o,
        output valid_o,
        input  imem_data_i,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i
    );

    modport slave (
        input  imem_addr_o,
        input  instr_o,
        input  imm_o,
        input  pc_plus4_o,
        input  valid_o,
        output imem_data_i,
        output stall_i,
        output redirect_i,
        output redirect_pc_i
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch response that
// lands while decode is stalled; clear wins over load.
module fetch_skid_buf #(
    parameter int W = mips_pkg::INSTR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] pc_i,
    output logic         vld_o,
    output logic [W-1:0] data_o,
    output logic [W-1:0] pc_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] pc_q, pc_d;

    // Next entry: drained/cleared, newly captured, or held.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (clear_i) begin
            vld_d  = 1'b0;
            data_d = '0;
            pc_d   = '0;
        end else if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
            pc_d   = pc_i;
        end
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/if_id_stage.sv
// MIPS fetch stage and IF/ID register: PC, in-flight
// response tag, skid for stalls, redirect squash.
module if_id_stage #(
    parameter int                 INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_id_stage_if.master bus
);

    import mips_pkg::*;

    logic               issue;
    logic [INSTR_W-1:0] redirect_tgt;

    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               resp_vld_q, resp_vld_d;
    logic [INSTR_W-1:0] resp_pc_q, resp_pc_d;
    fetch_state_e       state_q, state_d;

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc4_q, pc4_d;

    logic               skid_load, skid_clear, skid_vld;
    logic [INSTR_W-1:0] skid_data, skid_pc;

    assign issue        = !bus.stall_i && !bus.redirect_i;
    assign redirect_tgt = {bus.redirect_pc_i[INSTR_W-1:2], 2'b00};

    // A response arriving under stall parks in the skid;
    // any non-stalled cycle drains it, redirect drops it.
    assign skid_load  = bus.stall_i && resp_vld_q;
    assign skid_clear = bus.redirect_i || !bus.stall_i;

    fetch_skid_buf #(
        .W (INSTR_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (bus.imem_data_i),
        .pc_i    (resp_pc_q),
        .vld_o   (skid_vld),
        .data_o  (skid_data),
        .pc_o    (skid_pc)
    );

    // PC update and tagging of the fetch issued this cycle.
    always_comb begin
        pc_d       = pc_q;
        resp_vld_d = 1'b0;
        resp_pc_d  = resp_pc_q;
        if (bus.redirect_i) begin
            pc_d = redirect_tgt;
        end else if (issue) begin
            pc_d       = pc_q + INSTR_W'(PC_STEP);
            resp_vld_d = 1'b1;
            resp_pc_d  = pc_q;
        end
    end

    // Fetch FSM next state; redirect always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue) state_d = RUN;
            end
            RUN: begin
                if (bus.stall_i && resp_vld_q) state_d = HOLD;
                else if (!issue)               state_d = IDLE;
            end
            HOLD: begin
                if (!bus.stall_i) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (bus.redirect_i) state_d = IDLE;
    end

    // IF/ID source select: squash > hold > skid > response > bubble.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        priority case (1'b1)
            bus.redirect_i: begin
                valid_d = 1'b0;
                instr_d = INSTR_W'(NOP_WORD);
                pc4_d   = '0;
            end
            bus.stall_i: begin
            end
            skid_vld: begin
                valid_d = 1'b1;
                instr_d = skid_data;
                pc4_d   = skid_pc + INSTR_W'(PC_STEP);
            end
            resp_vld_q: begin
                valid_d = 1'b1;
                instr_d = bus.imem_data_i;
                pc4_d   = resp_pc_q + INSTR_W'(PC_STEP);
            end
            default: begin
                valid_d = 1'b0;
                instr_d = INSTR_W'(NOP_WORD);
                pc4_d   = '0;
            end
        endcase
    end

    // Fetch and IF/ID state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            resp_vld_q <= 1'b0;
            resp_pc_q  <= '0;
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc4_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_vld_q <= resp_vld_d;
            resp_pc_q  <= resp_pc_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
        end
    end

    assign bus.imem_addr_o = pc_q;
    assign bus.instr_o     = instr_q;
    assign bus.imm_o       = instr_q[15:0];
    assign bus.pc_plus4_o  = pc4_q;
    assign bus.valid_o     = valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: transaction-queue reference model,
// directed hazard scenarios and randomized stall/redirect.
module tb_if_id_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_id_stage_if bus ();
    if_id_stage_if bus2 ();

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2001_0005 ^ {a[15:0], a[15:0]};
    endfunction

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        bus.imem_data_i  <= mem_word(bus.imem_addr_o);
        bus2.imem_data_i <= mem_word(bus2.imem_addr_o);
    end

    // Reference model: fetches issued last cycle, words returned
    // but not yet delivered, and the expected IF/ID contents.
    logic [31:0]  m_fly[$];
    logic [31:0]  m_pend[$];
    logic [31:0]  m_pc;
    logic         m_valid;
    logic [31:0]  m_instr;
    logic [31:0]  m_pc4;
    logic [112:0] mexp;
    wire  [112:0] obs = {bus.valid_o, bus.instr_o, bus.imm_o,
                         bus.pc_plus4_o, bus.imem_addr_o};

    task automatic model_reset();
        m_fly.delete();
        m_pend.delete();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        mexp    = {m_valid, m_instr, m_instr[15:0], m_pc4, m_pc};
    endtask

    task automatic model_step(input logic st, input logic rd,
                              input logic [31:0] tg);
        logic [31:0] p;
        if (rd) begin
            m_fly.delete();
            m_pend.delete();
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_pc    = tg & 32'hFFFF_FFFC;
        end else begin
            while (m_fly.size() > 0) m_pend.push_back(m_fly.pop_front());
            if (!st) begin
                if (m_pend.size() > 0) begin
                    p       = m_pend.pop_front();
                    m_valid = 1'b1;
                    m_instr = mem_word(p);
                    m_pc4   = p + 32'd4;
                end else begin
                    m_valid = 1'b0;
                    m_instr = 32'h0;
                    m_pc4   = 32'h0;
                end
                m_fly.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        mexp = {m_valid, m_instr, m_instr[15:0], m_pc4, m_pc};
    endtask

    task automatic cyc(input logic st, input logic rd,
                       input logic [31:0] tg);
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tg;
        model_step(st, rd, tg);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 113'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", obs);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            checks++;
            if (obs !== mexp) begin
                errors++;
                $display("FAIL reset_seq[%0d] got=%h want=%h", i, obs, mexp);
            end
            if (i == 1) begin
                checks++;
                if (bus.valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL first_latency valid=%b want=0", bus.valid_o);
                end
            end
            if (i == 2) begin
                checks++;
                if ({bus.valid_o, bus.instr_o, bus.imm_o, bus.pc_plus4_o}
                    !== {1'b1, 32'h2001_0005, 16'h0005, 32'h4}) begin
                    errors++;
                    $display("FAIL first_instr v=%b i=%h imm=%h p4=%h want 1/20010005/0005/4",
                             bus.valid_o, bus.instr_o, bus.imm_o, bus.pc_plus4_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc_plus4_o !== 32'h10 || bus.imem_addr_o !== 32'h14) begin
            errors++;
            $display("FAIL stall_pre p4=%h a=%h want 10/14", bus.pc_plus4_o, bus.imem_addr_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            checks++;
            if (obs !== mexp || bus.pc_plus4_o !== 32'h10 || bus.imem_addr_o !== 32'h14) begin
                errors++;
                $display("FAIL stall_frozen[%0d] got=%h want=%h", i, obs, mexp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            checks++;
            if (obs !== mexp || bus.valid_o !== 1'b1
                || bus.pc_plus4_o !== 32'h14 + 32'(4 * i)
                || bus.instr_o !== mem_word(32'h10 + 32'(4 * i))) begin
                errors++;
                $display("FAIL stall_release[%0d] got=%h want=%h", i, obs, mexp);
            end
        end
    endtask

    task automatic test_redirect();
        cyc(1'b0, 1'b1, 32'h40);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.imem_addr_o !== 32'h40 || obs !== mexp) begin
            errors++;
            $display("FAIL redirect_squash got=%h want=%h", obs, mexp);
        end
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.valid_o !== 1'b0 || obs !== mexp) begin
            errors++;
            $display("FAIL redirect_gap got=%h want=%h", obs, mexp);
        end
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.pc_plus4_o !== 32'h44
            || bus.instr_o !== mem_word(32'h40) || obs !== mexp) begin
            errors++;
            $display("FAIL redirect_target got=%h want=%h", obs, mexp);
        end
    endtask

    task automatic test_redirect_hold();
        logic [31:0] tgt [2];
        logic        st  [2];
        tgt[0] = 32'h83;
        tgt[1] = 32'h100;
        st[0]  = 1'b1;
        st[1]  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, 32'h0);
            cyc(1'b0, 1'b0, 32'h0);
            cyc(1'b1, 1'b0, 32'h0);
            cyc(1'b1, 1'b0, 32'h0);
            cyc(st[k], 1'b1, tgt[k]);
            checks++;
            if (bus.valid_o !== 1'b0
                || bus.imem_addr_o !== (tgt[k] & 32'hFFFF_FFFC) || obs !== mexp) begin
                errors++;
                $display("FAIL hold_redirect[%0d] got=%h want=%h", k, obs, mexp);
            end
            cyc(1'b0, 1'b0, 32'h0);
            cyc(1'b0, 1'b0, 32'h0);
            checks++;
            if (bus.valid_o !== 1'b1
                || bus.pc_plus4_o !== (tgt[k] & 32'hFFFF_FFFC) + 32'd4
                || obs !== mexp) begin
                errors++;
                $display("FAIL hold_resume[%0d] got=%h want=%h", k, obs, mexp);
            end
        end
    endtask

    task automatic test_random();
        logic        st, rd;
        logic [31:0] tg;
        int          bad = 0;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom % 100) < 30;
            rd = ($urandom % 100) < 6;
            tg = $urandom & 32'h0000_0FFF;
            cyc(st, rd, tg);
            checks++;
            if (obs !== mexp) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d] st=%b rd=%b got=%h want=%h",
                             i, st, rd, obs, mexp);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 113'h0 || bus2.imem_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL async_reset got=%h a2=%h want=0/fffffffc",
                     obs, bus2.imem_addr_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            checks++;
            if (obs !== mexp) begin
                errors++;
                $display("FAIL restart[%0d] got=%h want=%h", i, obs, mexp);
            end
        end
        checks++;
        if (bus.valid_o !== 1'b1 || bus.pc_plus4_o !== 32'h8) begin
            errors++;
            $display("FAIL restart_seq v=%b p4=%h want 1/8", bus.valid_o, bus.pc_plus4_o);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus2.imem_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_reset a=%h want fffffffc", bus2.imem_addr_o);
        end
        rst_n = 1'b1;
        model_reset();
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus2.imem_addr_o !== 32'h0 || bus2.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_addr a=%h v=%b want 0/0", bus2.imem_addr_o, bus2.valid_o);
        end
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus2.valid_o !== 1'b1 || bus2.pc_plus4_o !== 32'h0
            || bus2.instr_o !== mem_word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_first v=%b p4=%h i=%h", bus2.valid_o,
                     bus2.pc_plus4_o, bus2.instr_o);
        end
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus2.pc_plus4_o !== 32'h4 || bus2.instr_o !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL wrap_second p4=%h i=%h want 4/%h", bus2.pc_plus4_o,
                     bus2.instr_o, mem_word(32'h0));
        end
    endtask

    initial begin
        bus2.stall_i       = 1'b0;
        bus2.redirect_i    = 1'b0;
        bus2.redirect_pc_i = 32'h0;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_hold();
        test_random();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
